neuron_step_sched: RTL and testbench
====================================

Name: neuron_step_sched

Overview:
Sequencing controller for the 21-bit signed Q12.9 membrane-potential register and its update datapath.
- Runs a neuron for a requested number of time steps.
- Drives the register's synchronous `set` (preset to V_RESET) and a capture enable.
- Waits out the datapath compute latency, compares the potential against threshold, and emits spikes.
- Applies a refractory period and reports completion.

Parameters:
- W, 21: potential width (signed, Q12.9).
- V_RESET, 21'sh01400: reset/initial potential, 10.0 in Q12.9; must match the register's preset constant.
- V_THRESH, 21'sh03C00: spike threshold, 30.0.
- CALC_LAT, 3: datapath cycles from stable v_q to valid next value; legal range 1..15.
- REFRAC, 2: refractory steps after a spike; legal range 0..15.
- CNT_W, 16: width of the step and spike counters.

Ports:
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- start, in, 1: begin a run; sampled only in IDLE.
- abort, in, 1: terminate a run; sampled in any busy state.
- n_steps, in, CNT_W: number of time steps; latched on start.
- v_q, in, W signed: current potential, from the register output.
- v_set, out, 1: drives the register's set input (load V_RESET).
- v_en, out, 1: capture enable for the datapath's next value.
- spike, out, 1: one-cycle spike pulse.
- busy, out, 1: high while a run is active.
- done, out, 1: one-cycle completion pulse.
- aborted, out, 1: qualifies done; high if the run ended by abort.
- step_idx, out, CNT_W: number of steps completed so far.
- spike_count, out, CNT_W: spikes emitted in the current run.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - All outputs and counters go to 0.
  - v_q is don't-care until the first INIT.
- States: IDLE, INIT, CALC, UPDATE, CHECK, REFR, DONE.
- IDLE:
  - busy=0.
  - On start=1, latch n_steps.
  - If n_steps==0, go to DONE (no v_set). Otherwise go to INIT.
- INIT (1 cycle): v_set=1; clear step_idx and spike_count; go to CALC.
- CALC: v_en=0 and v_set=0. Hold for exactly CALC_LAT cycles using a latency counter, then go to UPDATE.
- UPDATE (1 cycle): v_en=1; go to CHECK.
- CHECK (1 cycle): evaluates the v_q captured at the UPDATE edge. The comparison is signed, v_q >= V_THRESH, so equality spikes.
  - On spike:
    - spike=1 and v_set=1 in the same cycle.
    - spike_count increments, saturating at all-ones.
    - Refractory counter loads REFRAC.
  - step_idx increments in all cases.
  - Next state:
    - If step_idx+1 == n_steps, go to DONE. This takes priority over refractory.
    - Else if spiked and REFRAC>0, go to REFR.
    - Otherwise go to CALC.
- REFR: 1 cycle per refractory step.
  - v_en=0, v_set=0; the potential holds V_RESET.
  - step_idx increments and the refractory counter decrements each cycle.
  - When step_idx reaches n_steps, go to DONE.
  - When the refractory counter reaches 0, go to CALC.
- DONE (1 cycle): done=1, busy=0, then go to IDLE. step_idx and spike_count hold until the next INIT.
- busy=1 in INIT, CALC, UPDATE, CHECK and REFR.
- Timing: a non-spiking step takes CALC_LAT+2 cycles. With start sampled at edge 0, INIT is cycle 1 and the first v_en is cycle 2+CALC_LAT.
- start while busy is ignored.
- abort:
  - In any busy state, go to DONE next edge with aborted=1.
  - abort takes priority over the CHECK transition, but a spike in that same CHECK cycle still pulses and is counted.
  - aborted clears on the next start.
- Outputs are registered, or decoded purely from state. No combinational path from v_q to any output except spike and v_set, which are decoded in CHECK.

Decomposition:
- Package neuron_pkg: W, FRAC=9, V_RESET, V_THRESH, and the state enum.
- V_RESET is shared with the potential register so both presets stay identical.
- No sub-module; the latency, refractory and step counters are inline.

Test Plan:
All scenarios use CALC_LAT=3, REFRAC=2, and a datapath stub with v_next = v_q + k.
1. k=1.0 (512), n_steps=4, start at cycle 0 → v_set in cycle 1; v_en in cycles 5, 10, 15, 20; done in cycle 22; spike_count=0; v_q=0x1C00 (14.0).
2. k=8.0 (4096), n_steps=6 → v runs 18, 26, 34; spike in the CHECK of step 3; steps 4–5 are refractory (no v_en); step 6 gives v=0x2400 (18.0); spike_count=1; step_idx=6.
3. Stub forces v=0x3C00 (exactly 30.0) → spike=1 (>= boundary). Forcing 0x3BFF → no spike.
4. n_steps=0 → done in cycle 1; busy never asserts; v_set never asserts.
5. abort asserted in the first REFR cycle of scenario 2 → done next cycle with aborted=1; step_idx=4; spike_count=1. A following start clears aborted.
6. rst_n low in the 2nd CALC cycle → busy, v_en and v_set go 0 immediately (async). After release, start and n_steps=1 complete normally with done in cycle 7.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared constants and FSM state encoding for the neuron step scheduler.
// V_RESET is also used by the membrane-potential register so both presets match.
package neuron_pkg;

    localparam int W    = 21;
    localparam int FRAC = 9;

    // 10.0 in Q12.9: preset value of the potential register
    localparam logic signed [W-1:0] V_RESET  = 21'sh01400;
    // 30.0 in Q12.9: spike threshold (inclusive)
    localparam logic signed [W-1:0] V_THRESH = 21'sh03C00;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT   = 3'd1,
        S_CALC   = 3'd2,
        S_UPDATE = 3'd3,
        S_CHECK  = 3'd4,
        S_REFR   = 3'd5,
        S_DONE   = 3'd6
    } state_t;

endpackage

// File: rtl/neuron_step_sched.sv
// Sequencing controller for a Q12.9 membrane-potential register and its update
// datapath: presets the potential, waits out the compute latency, captures the
// next value, thresholds it, emits spikes and applies a refractory period.
module neuron_step_sched #(
    parameter int                            W        = neuron_pkg::W,
    parameter logic signed [neuron_pkg::W-1:0] V_RESET  = neuron_pkg::V_RESET,
    parameter logic signed [neuron_pkg::W-1:0] V_THRESH = neuron_pkg::V_THRESH,
    parameter int                            CALC_LAT = 3,
    parameter int                            REFRAC   = 2,
    parameter int                            CNT_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [CNT_W-1:0]        n_steps,
    input  logic signed [W-1:0]     v_q,
    output logic                    v_set,
    output logic                    v_en,
    output logic                    spike,
    output logic                    busy,
    output logic                    done,
    output logic                    aborted,
    output logic [CNT_W-1:0]        step_idx,
    output logic [CNT_W-1:0]        spike_count
);

    import neuron_pkg::*;

    // Counter reload values; the latency counter counts CALC_LAT-1 down to 0
    localparam logic [3:0] LAT_LOAD   = 4'(CALC_LAT - 1);
    localparam logic [3:0] REFR_LOAD  = 4'(REFRAC);
    localparam logic [3:0] CNT4_ZERO  = 4'd0;
    localparam logic [3:0] CNT4_ONE   = 4'd1;

    state_t           state;
    logic [CNT_W-1:0] n_lat;
    logic [3:0]       lat_cnt;
    logic [3:0]       refr_cnt;
    logic [CNT_W-1:0] step_inc;
    logic             spike_hit;
    logic             busy_state;

    // Threshold decode: only CHECK looks at v_q, and the compare is signed and inclusive
    always_comb begin
        spike_hit  = (state == S_CHECK) && (v_q >= V_THRESH);
        busy_state = (state == S_INIT) || (state == S_CALC) || (state == S_UPDATE) ||
                     (state == S_CHECK) || (state == S_REFR);
        step_inc   = step_idx + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    // Outputs decoded from state; spike and v_set additionally see the CHECK compare
    assign spike = spike_hit;
    assign v_set = (state == S_INIT) || spike_hit;
    assign v_en  = (state == S_UPDATE);
    assign busy  = busy_state;
    assign done  = (state == S_DONE);

    // Main sequencer: state, step/spike/latency/refractory counters and abort flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            n_lat       <= '0;
            lat_cnt     <= 4'd0;
            refr_cnt    <= 4'd0;
            step_idx    <= '0;
            spike_count <= '0;
            aborted     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        n_lat   <= n_steps;
                        aborted <= 1'b0;
                        state   <= (n_steps == '0) ? S_DONE : S_INIT;
                    end
                end
                S_INIT: begin
                    step_idx    <= '0;
                    spike_count <= '0;
                    lat_cnt     <= LAT_LOAD;
                    state       <= S_CALC;
                end
                S_CALC: begin
                    if (lat_cnt == CNT4_ZERO) begin
                        state <= S_UPDATE;
                    end else begin
                        lat_cnt <= lat_cnt - CNT4_ONE;
                    end
                end
                S_UPDATE: begin
                    state <= S_CHECK;
                end
                S_CHECK: begin
                    step_idx <= step_inc;
                    if (spike_hit) begin
                        refr_cnt <= REFR_LOAD;
                        if (spike_count != '1) begin
                            spike_count <= spike_count + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                    // Finishing the run wins over entering refractory
                    if (step_inc == n_lat) begin
                        state <= S_DONE;
                    end else if (spike_hit && (REFR_LOAD != CNT4_ZERO)) begin
                        state <= S_REFR;
                    end else begin
                        lat_cnt <= LAT_LOAD;
                        state   <= S_CALC;
                    end
                end
                S_REFR: begin
                    step_idx <= step_inc;
                    refr_cnt <= refr_cnt - CNT4_ONE;
                    if (step_inc == n_lat) begin
                        state <= S_DONE;
                    end else if (refr_cnt == CNT4_ONE) begin
                        lat_cnt <= LAT_LOAD;
                        state   <= S_CALC;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
            // Abort overrides only the next state; counter updates of this cycle still happen
            if (abort && busy_state) begin
                state   <= S_DONE;
                aborted <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_neuron_step_sched.sv
// Directed bench for neuron_step_sched with a potential-register stub
// (v_next = v_q + k, or a forced value) driven by v_set / v_en.
module tb_neuron_step_sched;
    import neuron_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic                abort = 1'b0;
    logic [15:0]         n_steps = 16'd0;
    logic signed [20:0]  v_q;
    logic                v_set, v_en, spike, busy, done, aborted;
    logic [15:0]         step_idx, spike_count;

    logic signed [20:0]  k_add = 21'sd0;
    logic signed [20:0]  f_val = 21'sd0;
    logic                f_mode = 1'b0;

    int total = 0;
    int bad = 0;

    // results of one run
    int          r_done_cyc;
    int          r_pulses;
    logic [31:0] r_ven;
    logic [31:0] r_vset;
    logic        r_busy_any;
    logic        r_ab_c1;
    logic        r_ab_done;

    neuron_step_sched #(.CALC_LAT(3), .REFRAC(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .n_steps(n_steps),
        .v_q(v_q), .v_set(v_set), .v_en(v_en), .spike(spike), .busy(busy),
        .done(done), .aborted(aborted), .step_idx(step_idx), .spike_count(spike_count)
    );

    always #5 clk = ~clk;

    // Potential register stub with synchronous preset and capture enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     v_q <= 21'sd0;
        else if (v_set) v_q <= V_RESET;
        else if (v_en)  v_q <= f_mode ? f_val : v_q + k_add;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Start a run (start sampled at edge 0) and follow it to done; optional abort in abort_cyc
    task automatic run(input logic [15:0] n, input int abort_cyc);
        r_done_cyc = -1; r_pulses = 0; r_ven = 32'd0; r_vset = 32'd0;
        r_busy_any = 1'b0; r_ab_done = 1'b0;
        n_steps = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        r_ab_c1 = aborted;
        for (int c = 1; c < 60; c++) begin
            abort = (c == abort_cyc);
            if (v_en && c < 32)  r_ven  = r_ven  | (32'd1 << c);
            if (v_set && c < 32) r_vset = r_vset | (32'd1 << c);
            if (spike) r_pulses++;
            if (busy) r_busy_any = 1'b1;
            if (done) begin
                r_done_cyc = c;
                r_ab_done = aborted;
                break;
            end
            @(posedge clk); #1;
        end
        abort = 1'b0;
    endtask

    typedef struct {
        logic [15:0] n;
        logic [20:0] k;
        logic        fm;
        logic [20:0] fv;
        int          done_cyc;
        logic [15:0] step;
        logic [15:0] spk;
        logic [20:0] v;
        int          pulses;
        logic [31:0] ven;
        logic [31:0] vset;
        logic        busy_any;
    } vec_t;

    vec_t vecs[8];

    initial begin
        //           n      k        fm    fv         done step   spk    v          pulses ven           vset          busy
        vecs[0] = '{16'd4, 21'd512,  1'b0, 21'h00000, 22, 16'd4, 16'd0, 21'h01C00, 0, 32'h00108420, 32'h00000002, 1'b1};
        vecs[1] = '{16'd0, 21'd512,  1'b0, 21'h00000, 1,  16'd4, 16'd0, 21'h01C00, 0, 32'h00000000, 32'h00000000, 1'b0};
        vecs[2] = '{16'd6, 21'd4096, 1'b0, 21'h00000, 24, 16'd6, 16'd1, 21'h02400, 1, 32'h00408420, 32'h00010002, 1'b1};
        vecs[3] = '{16'd1, 21'd0,    1'b1, 21'h03C00, 7,  16'd1, 16'd1, 21'h01400, 1, 32'h00000020, 32'h00000042, 1'b1};
        vecs[4] = '{16'd1, 21'd0,    1'b1, 21'h03BFF, 7,  16'd1, 16'd0, 21'h03BFF, 0, 32'h00000020, 32'h00000002, 1'b1};
        vecs[5] = '{16'd1, 21'd0,    1'b1, 21'h100000, 7, 16'd1, 16'd0, 21'h100000, 0, 32'h00000020, 32'h00000002, 1'b1};
        vecs[6] = '{16'd3, 21'd4096, 1'b0, 21'h00000, 17, 16'd3, 16'd1, 21'h01400, 1, 32'h00008420, 32'h00010002, 1'b1};
        vecs[7] = '{16'd4, 21'd4096, 1'b0, 21'h00000, 18, 16'd4, 16'd1, 21'h01400, 1, 32'h00008420, 32'h00010002, 1'b1};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_vset_ven_spike", {29'd0, v_set, v_en, spike}, 32'd0);
        chk("rst_aborted", {31'd0, aborted}, 32'd0);
        chk("rst_counters", {step_idx, spike_count}, 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // table-driven runs
        for (int i = 0; i < 8; i++) begin
            k_add = vecs[i].k; f_mode = vecs[i].fm; f_val = vecs[i].fv;
            run(vecs[i].n, 0);
            chk($sformatf("v%0d_done_cyc", i), r_done_cyc, vecs[i].done_cyc);
            chk($sformatf("v%0d_step_idx", i), {16'd0, step_idx}, {16'd0, vecs[i].step});
            chk($sformatf("v%0d_spike_count", i), {16'd0, spike_count}, {16'd0, vecs[i].spk});
            chk($sformatf("v%0d_v", i), {11'd0, v_q}, {11'd0, vecs[i].v});
            chk($sformatf("v%0d_pulses", i), r_pulses, vecs[i].pulses);
            chk($sformatf("v%0d_ven_cycles", i), r_ven, vecs[i].ven);
            chk($sformatf("v%0d_vset_cycles", i), r_vset, vecs[i].vset);
            chk($sformatf("v%0d_busy_any", i), {31'd0, r_busy_any}, {31'd0, vecs[i].busy_any});
            chk($sformatf("v%0d_aborted", i), {31'd0, r_ab_done}, 32'd0);
            @(posedge clk); #1;
        end

        // abort in the first refractory cycle (cycle 17) of the k=8.0, 6-step run
        k_add = 21'sd4096; f_mode = 1'b0;
        run(16'd6, 17);
        chk("abr_done_cyc", r_done_cyc, 18);
        chk("abr_aborted", {31'd0, r_ab_done}, 32'd1);
        chk("abr_step_idx", {16'd0, step_idx}, 32'd4);
        chk("abr_spike_count", {16'd0, spike_count}, 32'd1);
        @(posedge clk); #1;
        chk("abr_held_idle", {31'd0, aborted}, 32'd1);

        // next start clears aborted and runs normally
        k_add = 21'sd512;
        run(16'd1, 0);
        chk("post_abr_ab_c1", {31'd0, r_ab_c1}, 32'd0);
        chk("post_abr_done_cyc", r_done_cyc, 7);
        chk("post_abr_aborted", {31'd0, r_ab_done}, 32'd0);
        @(posedge clk); #1;

        // abort during a spiking CHECK: spike still pulses and counts
        f_mode = 1'b1; f_val = 21'sh03C00;
        run(16'd3, 6);
        chk("abchk_pulses", r_pulses, 1);
        chk("abchk_done_cyc", r_done_cyc, 7);
        chk("abchk_aborted", {31'd0, r_ab_done}, 32'd1);
        chk("abchk_counts", {step_idx, spike_count}, {16'd1, 16'd1});
        @(posedge clk); #1;

        // asynchronous reset in the second CALC cycle
        f_mode = 1'b0; k_add = 21'sd512;
        n_steps = 16'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("areset_pre_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("areset_busy", {31'd0, busy}, 32'd0);
        chk("areset_ven_vset", {30'd0, v_en, v_set}, 32'd0);
        chk("areset_counters", {step_idx, spike_count}, 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        run(16'd1, 0);
        chk("areset_after_done_cyc", r_done_cyc, 7);
        chk("areset_after_step_idx", {16'd0, step_idx}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
